// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ctrl
// Purpose  : Register-bus controller in front of a UART transceiver core.
//            It owns the baud divisor and buffers TX bytes in a FIFO, launching
//            them one at a time with a start pulse. It drains bytes received by
//            the core into an RX FIFO, acknowledging each with a has-byte clear
//            and flagging overflow. It also raises a level interrupt.
// Ports    : clk, rst                  - clock, async active-high reset
//            addr/wdata/we/re/rdata    - CPU register bus (0 DATA, 1 STATUS,
//                                        2 DIV_LO, 3 DIV_HI), 1-cycle read
//            irq                       - registered level interrupt
//            uart_divisor/din/start    - towards the core (TX side)
//            uart_busy/dout/has_byte   - from the core
//            uart_clr_hb               - has-byte acknowledge to the core
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_ctrl #(
    parameter int          DEPTH_LOG2  = 3,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    input  logic        re,
    output logic [7:0]  rdata,
    output logic        irq,
    output logic [15:0] uart_divisor,
    output logic [7:0]  uart_din,
    output logic        uart_start,
    input  logic        uart_busy,
    input  logic [7:0]  uart_dout,
    input  logic        uart_has_byte,
    output logic        uart_clr_hb
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] c_addr_data   = 2'd0;
    localparam logic [1:0] c_addr_status = 2'd1;
    localparam logic [1:0] c_addr_div_lo = 2'd2;
    localparam logic [1:0] c_addr_div_hi = 2'd3;

    localparam logic [DEPTH_LOG2-1:0] c_ptr_one  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   c_cnt_one  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   c_cnt_full = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] c_tx_idle      = 2'd0;
    localparam logic [1:0] c_tx_wait_busy = 2'd1;
    localparam logic [1:0] c_tx_wait_done = 2'd2;

    localparam logic [0:0] c_rx_idle = 1'b0;
    localparam logic [0:0] c_rx_ack  = 1'b1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]            r_tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wptr, r_tx_rptr;
    logic [DEPTH_LOG2:0]   r_tx_count;

    logic [7:0]            r_rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rx_wptr, r_rx_rptr;
    logic [DEPTH_LOG2:0]   r_rx_count;

    logic [1:0]  r_tx_state, w_tx_next;
    logic [1:0]  r_guard;
    logic [0:0]  r_rx_state, w_rx_next;

    logic        r_overflow, r_rx_ie, r_tx_ie;
    logic [15:0] r_divisor;
    logic [7:0]  r_rdata, r_din;
    logic        r_start, r_clr_hb, r_irq;

    // ------------------------------------------------------------------
    // Derived flags and bus decodes
    // ------------------------------------------------------------------
    logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic w_wr_data, w_wr_status, w_rd_data;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic w_tx_launch, w_rx_take, w_ovf_set;

    assign w_tx_empty = (r_tx_count == '0);
    assign w_tx_full  = (r_tx_count == c_cnt_full);
    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_full  = (r_rx_count == c_cnt_full);

    assign w_wr_data   = we && (addr == c_addr_data);
    assign w_wr_status = we && (addr == c_addr_status);
    assign w_rd_data   = re && (addr == c_addr_data);

    // Fullness/emptiness are the pre-edge values, so a same-cycle pop never
    // makes room for a push and a pop of an empty FIFO is simply ignored.
    assign w_tx_push = w_wr_data && !w_tx_full;
    assign w_tx_pop  = w_tx_launch;
    assign w_rx_push = w_rx_take && !w_rx_full;
    assign w_ovf_set = w_rx_take && w_rx_full;
    assign w_rx_pop  = w_rd_data && !w_rx_empty;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_ptr_one;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_ptr_one;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + c_cnt_one;
                2'b01:   r_tx_count <= r_tx_count - c_cnt_one;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= uart_dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_ptr_one;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_ptr_one;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + c_cnt_one;
                2'b01:   r_rx_count <= r_rx_count - c_cnt_one;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= c_tx_idle;
            r_guard    <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            // Guard timer so a start the core never acknowledges cannot
            // stall the FSM in WAIT_BUSY.
            r_guard    <= (r_tx_state == c_tx_wait_busy) ? r_guard + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            c_tx_idle:      if (!w_tx_empty && !uart_busy)      w_tx_next = c_tx_wait_busy;
            c_tx_wait_busy: if (uart_busy || (r_guard == 2'd2)) w_tx_next = c_tx_wait_done;
            c_tx_wait_done: if (!uart_busy)                     w_tx_next = c_tx_idle;
            default:                                            w_tx_next = c_tx_idle;
        endcase
    end

    always_comb begin
        w_tx_launch = (r_tx_state == c_tx_idle) && !w_tx_empty && !uart_busy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= 1'b0;
            r_din   <= '0;
        end else begin
            r_start <= w_tx_launch;
            if (w_tx_launch) r_din <= r_tx_mem[r_tx_rptr];
        end
    end

    // ------------------------------------------------------------------
    // RX FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= c_rx_idle;
        else     r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            c_rx_idle: if (uart_has_byte) w_rx_next = c_rx_ack;
            default:                      w_rx_next = c_rx_idle;
        endcase
    end

    // RX_ACK lasts one cycle so the stale has_byte is not taken twice while
    // the clear travels to the core.
    always_comb begin
        w_rx_take = (r_rx_state == c_rx_idle) && uart_has_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_clr_hb <= 1'b0;
        else     r_clr_hb <= w_rx_take;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_rx_ie    <= 1'b0;
            r_tx_ie    <= 1'b0;
            r_divisor  <= DEFAULT_DIV;
        end else begin
            // A new overflow wins over a simultaneous clear so it is not lost.
            if (w_ovf_set)                       r_overflow <= 1'b1;
            else if (w_wr_status && wdata[4])    r_overflow <= 1'b0;
            if (w_wr_status) begin
                r_rx_ie <= wdata[6];
                r_tx_ie <= wdata[7];
            end
            if (we && (addr == c_addr_div_lo))   r_divisor[7:0]  <= wdata;
            if (we && (addr == c_addr_div_hi))   r_divisor[15:8] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read data and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            case (addr)
                c_addr_data:   r_rdata <= w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];
                c_addr_status: r_rdata <= {r_tx_ie, r_rx_ie, w_rx_full, r_overflow,
                                           uart_busy, w_tx_empty, w_tx_full, !w_rx_empty};
                c_addr_div_lo: r_rdata <= r_divisor[7:0];
                default:       r_rdata <= r_divisor[15:8];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_rx_ie && (!w_rx_empty || r_overflow)) ||
                     (r_tx_ie && w_tx_empty && (r_tx_state == c_tx_idle) && !uart_busy);
        end
    end

    assign rdata        = r_rdata;
    assign irq          = r_irq;
    assign uart_divisor = r_divisor;
    assign uart_din     = r_din;
    assign uart_start   = r_start;
    assign uart_clr_hb  = r_clr_hb;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_ctrl
// Purpose  : Scoreboard bench for uart_fifo_ctrl. Stimulus pushes expected
//            read data and expected transmit bytes into queues; monitors pop
//            and compare when the DUT presents rdata or a start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic        we, re;
    logic [7:0]  rdata;
    logic        irq;
    logic [15:0] uart_divisor;
    logic [7:0]  uart_din;
    logic        uart_start;
    logic        uart_busy;
    logic [7:0]  uart_dout;
    logic        uart_has_byte;
    logic        uart_clr_hb;

    int n_checks  = 0;
    int n_fail    = 0;
    int start_cnt = 0;
    int clr_cnt   = 0;
    int busy_cnt;
    logic force_busy = 1'b0;
    logic rd_fire;
    logic [7:0] rd_exp [$];
    logic [7:0] tx_exp [$];

    uart_fifo_ctrl #(.DEPTH_LOG2(3), .DEFAULT_DIV(16'd433)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .irq(irq), .uart_divisor(uart_divisor),
        .uart_din(uart_din), .uart_start(uart_start), .uart_busy(uart_busy),
        .uart_dout(uart_dout), .uart_has_byte(uart_has_byte),
        .uart_clr_hb(uart_clr_hb)
    );

    always #5 clk = ~clk;

    // Core model: busy for 20 cycles after each start, or forced high.
    assign uart_busy = force_busy || (busy_cnt != 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 0;
            rd_fire  <= 1'b0;
        end else begin
            rd_fire <= re;
            if (uart_start)         busy_cnt <= 20;
            else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares rdata and transmitted bytes against the scoreboard.
    always @(negedge clk) begin
        if (rd_fire) begin
            if (rd_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rdata_unexpected: got 0x%0h with no read expected", rdata);
            end else begin
                check("rdata", {24'h0, rdata}, {24'h0, rd_exp.pop_front()});
            end
        end
        if (uart_start) begin
            start_cnt++;
            check("start_while_busy", {31'h0, uart_busy}, 32'h0);
            if (tx_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL start_unexpected: got din 0x%0h with no byte expected", uart_din);
            end else begin
                check("uart_din", {24'h0, uart_din}, {24'h0, tx_exp.pop_front()});
            end
        end
        if (uart_clr_hb) clr_cnt++;
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] e);
        rd_exp.push_back(e);
        @(negedge clk);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        @(negedge clk);
    endtask

    task automatic inject(input logic [7:0] b);
        int k;
        @(negedge clk);
        uart_dout = b; uart_has_byte = 1'b1;
        k = 0;
        while (!uart_clr_hb && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("clr_hb_seen", {31'h0, uart_clr_hb}, 32'h1);
        uart_has_byte = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_starts(input int n);
        int k;
        k = 0;
        while (start_cnt < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("start_count", start_cnt, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
        uart_dout = '0; uart_has_byte = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdata",   {24'h0, rdata},  32'h0);
        check("rst_irq",     {31'h0, irq},    32'h0);
        check("rst_start",   {31'h0, uart_start}, 32'h0);
        check("rst_clr_hb",  {31'h0, uart_clr_hb}, 32'h0);
        check("rst_din",     {24'h0, uart_din}, 32'h0);
        check("rst_divisor", {16'h0, uart_divisor}, 32'h01B1);
        rst = 1'b0;

        rd(2'd1, 8'h04);
        rd(2'd2, 8'hB1);
        rd(2'd3, 8'h01);
        check("idle_irq", {31'h0, irq}, 32'h0);

        // Three bytes through the busy model, in order.
        tx_exp.push_back(8'h55); tx_exp.push_back(8'hA3); tx_exp.push_back(8'h0F);
        wr(2'd0, 8'h55); wr(2'd0, 8'hA3); wr(2'd0, 8'h0F);
        wait_starts(3);
        repeat (30) @(negedge clk);
        rd(2'd1, 8'h04);

        // Ten bytes with the core held busy: only eight fit.
        force_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) tx_exp.push_back(8'h80 + 8'(i));
            wr(2'd0, 8'h80 + 8'(i));
        end
        rd(2'd1, 8'h0A);
        force_busy = 1'b0;
        wait_starts(11);
        repeat (30) @(negedge clk);
        rd(2'd1, 8'h04);

        // Single received byte.
        c0 = clr_cnt;
        inject(8'h3C);
        check("clr_hb_one", clr_cnt - c0, 1);
        rd(2'd1, 8'h05);
        rd(2'd0, 8'h3C);
        rd(2'd1, 8'h04);
        rd(2'd0, 8'h00);

        // Nine received bytes: the ninth overflows.
        c0 = clr_cnt;
        for (int i = 0; i < 9; i++) inject(8'h10 + 8'(i));
        check("clr_hb_nine", clr_cnt - c0, 9);
        rd(2'd1, 8'h35);
        for (int i = 0; i < 8; i++) rd(2'd0, 8'h10 + 8'(i));
        rd(2'd1, 8'h14);
        wr(2'd1, 8'h10);
        rd(2'd1, 8'h04);

        // Interrupts.
        wr(2'd1, 8'h40);
        repeat (2) @(negedge clk);
        check("irq_rx_none", {31'h0, irq}, 32'h0);
        inject(8'hC7);
        check("irq_rx_set", {31'h0, irq}, 32'h1);
        rd(2'd0, 8'hC7);
        repeat (2) @(negedge clk);
        check("irq_rx_clr", {31'h0, irq}, 32'h0);
        wr(2'd1, 8'h80);
        repeat (2) @(negedge clk);
        check("irq_tx_set", {31'h0, irq}, 32'h1);
        wr(2'd1, 8'h00);
        repeat (2) @(negedge clk);
        check("irq_tx_clr", {31'h0, irq}, 32'h0);

        // Divisor update, then reset in the middle of a transmission.
        wr(2'd2, 8'h22); wr(2'd3, 8'h05);
        check("divisor_set", {16'h0, uart_divisor}, 32'h0522);
        rd(2'd2, 8'h22);
        tx_exp.push_back(8'h61);
        wr(2'd0, 8'h61); wr(2'd0, 8'h62); wr(2'd0, 8'h63);
        wait_starts(12);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_start",   {31'h0, uart_start}, 32'h0);
        check("mid_rst_din",     {24'h0, uart_din}, 32'h0);
        check("mid_rst_rdata",   {24'h0, rdata}, 32'h0);
        check("mid_rst_irq",     {31'h0, irq}, 32'h0);
        check("mid_rst_divisor", {16'h0, uart_divisor}, 32'h01B1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(2'd1, 8'h04);
        rd(2'd0, 8'h00);
        repeat (50) @(negedge clk);
        check("no_start_after_rst", start_cnt, 12);
        rd(2'd2, 8'hB1);

        check("rd_queue_drained", rd_exp.size(), 0);
        check("tx_queue_drained", tx_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Bus-facing controller that sequences the UART transceiver core and sits between the CPU register bus and that core. It owns the divisor register and buffers transmit bytes in a TX FIFO, issuing start pulses one byte at a time. It drains received bytes into an RX FIFO with has-byte acknowledgement and overflow detection, and raises a level interrupt.

Parameters:
DEPTH_LOG2, 3, log2 of each FIFO depth (default 8 entries per FIFO)
DEFAULT_DIV, 16'd433, divisor value loaded at reset

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
addr  in  2  register select: 0 DATA, 1 STATUS, 2 DIV_LO, 3 DIV_HI
wdata  in  8  write data
we  in  1  write strobe, single cycle
re  in  1  read strobe, single cycle
rdata  out  8  registered read data
irq  out  1  level interrupt
uart_divisor  out  16  divisor to core
uart_din  out  8  TX byte to core
uart_start  out  1  one-cycle start pulse to core
uart_busy  in  1  core transmitting
uart_dout  in  8  received byte from core
uart_has_byte  in  1  core holds a received byte
uart_clr_hb  out  1  one-cycle has-byte clear to core

Behaviour:
- Reset (async, immediate):
  - rdata=0, irq=0, uart_start=0, uart_clr_hb=0, uart_din=0, uart_divisor=DEFAULT_DIV.
  - Both FIFOs empty; overflow=0; rx_ie=0; tx_ie=0; TX FSM in IDLE; RX FSM in RX_IDLE.
  - Reset mid-transfer drops all buffered data and takes effect in the same cycle.
- Writes (we=1):
  - DATA: push wdata into TX FIFO. If the TX FIFO is full, the byte is dropped. Fullness is judged before any same-cycle pop.
  - STATUS: bit4=1 clears overflow (W1C); bit6 loads rx_ie; bit7 loads tx_ie.
  - DIV_LO / DIV_HI: load uart_divisor[7:0] / [15:8]. Takes effect immediately. Software changes it only when tx_empty=1 and busy=0.
- Reads: rdata updates on the clock edge after re (1-cycle latency); it holds its value when re=0.
  - DATA: returns the RX FIFO head and pops it in the re cycle. If the RX FIFO is empty, returns 0x00 with no pointer change.
  - STATUS: {tx_ie, rx_ie, rx_full, overflow, uart_busy, tx_empty, tx_full, rx_nonempty} (bit7..bit0).
  - DIV_LO / DIV_HI: return the divisor bytes.
- FIFOs:
  - 2^DEPTH_LOG2 entries each; pointers are DEPTH_LOG2 bits and wrap; the count is DEPTH_LOG2+1 bits.
  - Simultaneous push+pop on a non-empty FIFO: both occur and the count is unchanged.
  - Push+pop on an empty RX FIFO: the push occurs and the pop is ignored.
- TX FSM:
  - IDLE: when the TX FIFO is non-empty and uart_busy=0, register uart_din=head, pulse uart_start for 1 cycle, pop, go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when uart_busy=1, or after 3 cycles (guard counter).
  - WAIT_DONE: go to IDLE when uart_busy=0.
  - uart_din holds stable until the next start. Bytes leave in FIFO order with no back-to-back starts while busy.
- RX FSM:
  - RX_IDLE: when uart_has_byte=1, either push uart_dout (RX FIFO not full) or set overflow and drop the byte (full). In both cases pulse uart_clr_hb for 1 cycle and go to RX_ACK.
  - RX_ACK: one cycle, ignoring has_byte while the clear propagates, then return to RX_IDLE.
  - A pop in the same cycle as a push to a full RX FIFO does not free space for that push, so overflow is still set.
  - overflow is sticky until W1C or reset.
- irq = registered (rx_ie & (rx_nonempty | overflow)) | (tx_ie & tx_empty & TX FSM in IDLE & !uart_busy).

Test Plan:
- Reset, then read STATUS / DIV_LO / DIV_HI -> 0x04, 0xB1, 0x01; uart_start=0 and irq=0 throughout.
- Write DATA 0x55, 0xA3, 0x0F while a busy model holds busy 20 cycles per byte -> exactly 3 uart_start pulses, each with uart_din 0x55, 0xA3, 0x0F in order; no start while busy=1; tx_empty=1 at the end.
- Write 10 DATA bytes with busy held high -> first 8 accepted (one may launch); STATUS tx_full=1; extra bytes dropped; the sequence transmitted matches the accepted bytes.
- Core model presents has_byte with dout 0x3C -> one uart_clr_hb pulse; rx_nonempty=1; DATA read returns 0x3C one cycle after re; then rx_nonempty=0; a DATA read of the empty FIFO returns 0x00.
- Inject 9 received bytes without reading -> 9 clr_hb pulses; overflow=1; reads return the first 8 bytes in order; STATUS write 0x10 clears overflow.
- rx_ie=1 with one byte received -> irq=1; pop it -> irq=0. Assert rst mid-transmit -> outputs and FIFOs return to reset values immediately.
